// File: rtl/hilo_mdu_seq_if.sv
// hilo_mdu_seq_if: execute-stage <-> HI/LO multiply/divide sequencer bus.
// master = core side (issues ops, reads HI/LO), slave = sequencer side.
interface hilo_mdu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             issue_valid;
  logic [2:0]       issue_op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             rd_req;
  logic             issue_ready;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output issue_valid, issue_op, rs_val, rt_val, rd_req,
    input  issue_ready, busy, stall, done, hi, lo
  );

  modport slave (
    input  issue_valid, issue_op, rs_val, rt_val, rd_req,
    output issue_ready, busy, stall, done, hi, lo
  );
endinterface

// File: rtl/hilo_mdu_seq.sv
// hilo_mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Optional macro MDU_FAST_MUL_EN: multiplies complete in a single cycle via an
// array multiplier; divides stay iterative. Undefined: all mul/div iterate.
module hilo_mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic            CLK,
  input logic            RST,
  hilo_mdu_seq_if.slave  bus
);
  localparam int unsigned W  = WIDTH;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W2-1:0] acc_q, acc_d;      // mul: running product; div: {remainder, quotient/dividend}
  logic [W-1:0]  opd_q, opd_d;      // mul: multiplicand magnitude; div: divisor magnitude
  logic          is_div_q, is_div_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          done_q, done_d;

  logic          sgn, a_neg, b_neg;
  logic [W-1:0]  abs_a, abs_b;
  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic [W:0]    div_diff;
  logic          busy;

  // Operand conditioning at the issue port
  assign sgn   = (bus.issue_op == OP_MULT) || (bus.issue_op == OP_DIV);
  assign a_neg = sgn & bus.rs_val[W-1];
  assign b_neg = sgn & bus.rt_val[W-1];
  assign abs_a = a_neg ? -bus.rs_val : bus.rs_val;
  assign abs_b = b_neg ? -bus.rt_val : bus.rt_val;

`ifdef MDU_FAST_MUL_EN
  logic [W2-1:0] fast_a, fast_b, fast_prod;
  // Low 2W bits of the sign/zero-extended product give the exact signed/unsigned result
  assign fast_a    = {{W{a_neg}}, bus.rs_val};
  assign fast_b    = {{W{b_neg}}, bus.rt_val};
  assign fast_prod = fast_a * fast_b;
`endif

  // One iteration of shift-add multiply and restoring divide
  assign mul_sum   = {1'b0, acc_q[W2-1:W]} + {1'b0, (acc_q[0] ? opd_q : {W{1'b0}})};
  assign div_shift = {acc_q[W2-1:W], acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};

  assign busy            = (state_q != IDLE);
  assign bus.busy        = busy;
  assign bus.issue_ready = (state_q == IDLE);
  assign bus.stall       = busy & (bus.rd_req | bus.issue_valid);
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Next-state, iteration step, sign fix-up and HI/LO write-back
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.issue_valid) begin
          case (bus.issue_op)
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
              {hi_d, lo_d} = fast_prod;
              done_d       = 1'b1;
`else
              state_d   = CALC;
              count_d   = '0;
              is_div_d  = 1'b0;
              opd_d     = abs_a;
              acc_d     = {{W{1'b0}}, abs_b};
              neg_quo_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
`endif
            end
            OP_DIV, OP_DIVU: begin
              if (bus.rt_val == '0) begin
                done_d = 1'b1;
              end else begin
                state_d   = CALC;
                count_d   = '0;
                is_div_d  = 1'b1;
                opd_d     = abs_b;
                acc_d     = {{W{1'b0}}, abs_a};
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
              end
            end
            default: ;
          endcase
        end
      end

      CALC: begin
        if (is_div_q) begin
          if (!div_diff[W]) acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
          else              acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = FIX;
      end

      FIX: begin
        if (is_div_q) begin
          lo_d = neg_quo_q ? -acc_q[W-1:0]  : acc_q[W-1:0];
          hi_d = neg_rem_q ? -acc_q[W2-1:W] : acc_q[W2-1:W];
        end else begin
          {hi_d, lo_d} = neg_quo_q ? -acc_q : acc_q;
        end
        count_d = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hilo_mdu_seq.sv
// tb_hilo_mdu_seq: directed + random checks of hilo_mdu_seq against an
// arithmetic HI/LO reference model. Honours MDU_FAST_MUL_EN when defined.
module tb_hilo_mdu_seq;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vectors = 0;
  int   errs    = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_mdu_seq_if #(.WIDTH(32)) bus ();
  hilo_mdu_seq #(.WIDTH(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result {hi,lo} after an op, from plain arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); return p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; return p; end
      3'd2: begin
        if (b == 0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {h, l};
        return {a % b, a / b};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  // Cycles from accept edge to done-high cycle; -1 when the op never pulses done
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
    case (op)
`ifdef MDU_FAST_MUL_EN
      3'd0, 3'd1: return 0;
`else
      3'd0, 3'd1: return 33;
`endif
      3'd2, 3'd3: return (b == 0) ? 0 : 33;
      default: return -1;
    endcase
  endfunction

  // Issue one op (caller is at a negedge) and follow it to completion
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit rd_from5);
    logic [63:0] exp;
    int lat, k, busy_n;
    exp = ref_model(op, a, b, m_hi, m_lo);
    lat = exp_lat(op, b);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.rs_val      = a;
    bus.rt_val      = b;
    bus.rd_req      = 1'b0;
    @(posedge CLK);
    #1;
    bus.issue_valid = 1'b0;
    bus.rs_val      = $urandom;
    bus.rt_val      = $urandom;
    @(negedge CLK);
    if (lat < 0) begin
      check("mt_busy", 64'(bus.busy), 64'(0));
      check("mt_done", 64'(bus.done), 64'(0));
      check("mt_hilo", {bus.hi, bus.lo}, exp);
      {m_hi, m_lo} = exp;
      return;
    end
    k = 0;
    busy_n = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) busy_n++;
      check("hold_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
      check("busy_ready", 64'(bus.issue_ready), 64'(0));
      check("busy_stall", 64'(bus.stall), 64'((k < lat) && (bus.rd_req || bus.issue_valid)));
      bus.rd_req      = rd_from5 ? (k + 1 >= 5) : ($urandom_range(0, 1) == 1);
      bus.issue_valid = ($urandom_range(0, 3) == 0);
      bus.issue_op    = 3'd4;
      bus.rs_val      = $urandom;
      @(negedge CLK);
      k++;
    end
    check("idle_stall", 64'(bus.stall), 64'(0));
    bus.issue_valid = 1'b0;
    bus.rd_req      = 1'b0;
    check("latency", 64'(k), 64'(lat));
    check("busy_cycles", 64'(busy_n), 64'(lat));
    check("done_pulse", 64'(bus.done), 64'(1));
    check("result", {bus.hi, bus.lo}, exp);
    check("ready_back", 64'(bus.issue_ready), 64'(1));
    {m_hi, m_lo} = exp;
    @(negedge CLK);
    check("done_one_cycle", 64'(bus.done), 64'(0));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int k;
    bus.issue_valid = 1'b0;
    bus.issue_op    = 3'd0;
    bus.rs_val      = '0;
    bus.rt_val      = '0;
    bus.rd_req      = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    bus.rd_req = 1'b1;
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_ready", 64'(bus.issue_ready), 64'(1));
    check("idle_rd_stall", 64'(bus.stall), 64'(0));
    bus.rd_req = 1'b0;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_m2x3", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'd3, 32'd100, 32'd7, 1'b0);
    check("divu_100_7", {bus.hi, bus.lo}, {32'd2, 32'd14});
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_wrap", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    run_op(3'd4, 32'h1234, 32'h0, 1'b0);
    run_op(3'd5, 32'h5678, 32'h0, 1'b0);
    run_op(3'd2, 32'd55, 32'd0, 1'b0);
    check("div0_keep", {bus.hi, bus.lo}, {32'h1234, 32'h5678});
    run_op(3'd7, 32'hDEAD, 32'hBEEF, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    // Reset in the middle of an operation
    bus.issue_valid = 1'b1;
    bus.issue_op    = 3'd2;
    bus.rs_val      = 32'd1000;
    bus.rt_val      = 32'd3;
    @(posedge CLK);
    #1;
    bus.issue_valid = 1'b0;
    for (k = 0; k < 10; k++) @(negedge CLK);
    check("pre_rst_busy", 64'(bus.busy), 64'(1));
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_ready", 64'(bus.issue_ready), 64'(1));
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    for (k = 0; k < 35; k++) begin
      @(negedge CLK);
      check("midrst_no_done", 64'(bus.done), 64'(0));
    end
    run_op(3'd3, 32'd9, 32'd3, 1'b0);
    check("divu_9_3", {bus.hi, bus.lo}, {32'd0, 32'd3});

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd1;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op(rop, ra, rb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
